// File: rtl/vga_seq_pkg.sv
// vga_seq_pkg: shared state encoding, default parameters and frame_tick position
package vga_seq_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        BLANK = 2'd2
    } seq_state_t;
    localparam int DEF_ANIM_W          = 10;
    localparam int DEF_NUM_PATTERNS    = 4;
    localparam int DEF_AUTO_FRAMES     = 300;
    localparam int DEF_BLANK_FRAMES    = 2;
    localparam int DEF_DEBOUNCE_FRAMES = 4;
    localparam int TICK_HPOS           = 0;
    localparam int TICK_VPOS           = 0;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// vga_pattern_sequencer_if: beam position, user controls and pattern-datapath outputs
//   master: sequencer side (takes hpos/vpos/buttons/auto_en/speed, drives pattern_sel/anim_count/blank/paused)
//   slave:  surrounding top level / pixel datapath side
interface vga_pattern_sequencer_if import vga_seq_pkg::*; #(
    parameter int ANIM_W = DEF_ANIM_W
);
    logic [9:0]        hpos;
    logic [9:0]        vpos;
    logic              btn_next;
    logic              btn_pause;
    logic              auto_en;
    logic [1:0]        speed;
    logic [1:0]        pattern_sel;
    logic [ANIM_W-1:0] anim_count;
    logic              blank;
    logic              paused;
    modport master (
        input  hpos, vpos, btn_next, btn_pause, auto_en, speed,
        output pattern_sel, anim_count, blank, paused
    );
    modport slave (
        output hpos, vpos, btn_next, btn_pause, auto_en, speed,
        input  pattern_sel, anim_count, blank, paused
    );
endinterface

// File: rtl/frame_debouncer.sv
// frame_debouncer: once-per-frame button debouncer
//   in:  clk, reset (sync, active-high), tick (frame strobe), raw (button)
//   out: level (debounced), press (combinational, high on the tick level goes 0->1)
module frame_debouncer import vga_seq_pkg::*; #(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = cnt_w(DEBOUNCE_FRAMES);
    logic [CW-1:0] cnt;
    logic          accept;
    // press is combinational so the FSM acts on the very tick the level flips
    assign accept = tick && (raw != level) && (cnt == CW'(DEBOUNCE_FRAMES - 1));
    assign press  = accept && raw;
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (tick) begin
            level <= accept ? raw : level;
            cnt   <= (raw == level || accept) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: per-frame animation phase, pattern switching with blanking gap, pause
//   in:  clk, reset (sync, active-high)
//   bus: hpos/vpos, btn_next, btn_pause, auto_en, speed -> pattern_sel, anim_count, blank, paused
module vga_pattern_sequencer import vga_seq_pkg::*; #(
    parameter int ANIM_W          = DEF_ANIM_W,
    parameter int NUM_PATTERNS    = DEF_NUM_PATTERNS,
    parameter int AUTO_FRAMES     = DEF_AUTO_FRAMES,
    parameter int BLANK_FRAMES    = DEF_BLANK_FRAMES,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input logic clk,
    input logic reset,
    vga_pattern_sequencer_if.master bus
);
    localparam int AW = cnt_w(AUTO_FRAMES);
    localparam int BW = cnt_w(BLANK_FRAMES);
    seq_state_t        state_q, state_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic [AW-1:0]     auto_q, auto_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [1:0]        psel_q, psel_d;
    logic              paused_q, paused_d;
    logic              tick, next_press, pause_press, switch_run;
    logic              unused_next_level, unused_pause_level;
    assign tick = (bus.hpos == 10'(TICK_HPOS)) && (bus.vpos == 10'(TICK_VPOS));
    frame_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_next (
        .clk(clk), .reset(reset), .tick(tick), .raw(bus.btn_next),
        .level(unused_next_level), .press(next_press)
    );
    frame_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_pause (
        .clk(clk), .reset(reset), .tick(tick), .raw(bus.btn_pause),
        .level(unused_pause_level), .press(pause_press)
    );
    // a manual press and auto expiry on the same tick collapse into one switch
    assign switch_run = next_press || (bus.auto_en && auto_q == AW'(AUTO_FRAMES - 1));
    always_comb begin
        state_d  = state_q;
        anim_d   = anim_q;
        auto_d   = auto_q;
        bcnt_d   = bcnt_q;
        psel_d   = psel_q;
        paused_d = paused_q;
        if (tick) begin
            case (state_q)
                RUN: begin
                    anim_d = anim_q + (ANIM_W'(1) << bus.speed);
                    auto_d = bus.auto_en ? auto_q + 1'b1 : auto_q;
                    if (switch_run) begin
                        state_d = BLANK;
                    end else if (pause_press) begin
                        state_d  = PAUSE;
                        paused_d = ~paused_q;
                    end
                end
                PAUSE: begin
                    if (next_press) begin
                        state_d = BLANK;
                    end else if (pause_press) begin
                        state_d  = RUN;
                        paused_d = ~paused_q;
                    end
                end
                default: begin
                    if (bcnt_q == BW'(BLANK_FRAMES - 1)) begin
                        psel_d  = (psel_q == 2'(NUM_PATTERNS - 1)) ? 2'd0 : psel_q + 1'b1;
                        anim_d  = '0;
                        auto_d  = '0;
                        bcnt_d  = '0;
                        state_d = paused_q ? PAUSE : RUN;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            anim_q   <= '0;
            auto_q   <= '0;
            bcnt_q   <= '0;
            psel_q   <= '0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            anim_q   <= anim_d;
            auto_q   <= auto_d;
            bcnt_q   <= bcnt_d;
            psel_q   <= psel_d;
            paused_q <= paused_d;
        end
    end
    assign bus.pattern_sel = psel_q;
    assign bus.anim_count  = anim_q;
    assign bus.blank       = (state_q == BLANK);
    assign bus.paused      = paused_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: directed and random stimulus against a frame-level reference model
module tb_vga_pattern_sequencer;
    import vga_seq_pkg::*;
    localparam int AF = 8;
    localparam int BF = 2;
    localparam int DF = 2;
    localparam int NP = 4;
    localparam bit [7:0] DMASK = 8'((1 << DF) - 1);
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pos = 4'd0;
    bit         hold_pos = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    int         m_sel, m_anim, m_autoc, m_left;
    bit         m_paused;
    bit [7:0]   h_next, h_pause;
    bit         l_next, l_pause;
    vga_pattern_sequencer_if #(.ANIM_W(10)) bus ();
    vga_pattern_sequencer #(
        .ANIM_W(10), .NUM_PATTERNS(NP), .AUTO_FRAMES(AF),
        .BLANK_FRAMES(BF), .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    // beam model: one frame_tick every 16 clk, freezable to starve the sequencer of ticks
    always @(posedge clk) if (!hold_pos) pos <= pos + 1'b1;
    assign bus.hpos = {6'd0, pos};
    assign bus.vpos = 10'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("pattern_sel", 32'(bus.pattern_sel), 32'(m_sel));
        chk("anim_count", 32'(bus.anim_count), 32'(m_anim));
        chk("blank", 32'(bus.blank), 32'(m_left > 0));
        chk("paused", 32'(bus.paused), 32'(m_paused));
    endtask

    task automatic model_reset();
        m_sel = 0; m_anim = 0; m_autoc = 0; m_left = 0; m_paused = 0;
        h_next = '0; h_pause = '0; l_next = 0; l_pause = 0;
    endtask

    // level flips once the last DF samples all disagree with it
    task automatic deb(input bit raw, inout bit [7:0] h, inout bit lvl, output bit press);
        h = {h[6:0], raw};
        press = 0;
        if ((h & DMASK) == (lvl ? 8'd0 : DMASK)) begin
            lvl = ~lvl;
            press = lvl;
        end
    endtask

    task automatic model_step();
        bit np, pp, expire;
        deb(bus.btn_next, h_next, l_next, np);
        deb(bus.btn_pause, h_pause, l_pause, pp);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_sel = (m_sel + 1) % NP;
                m_anim = 0;
                m_autoc = 0;
            end
        end else if (!m_paused) begin
            expire = bus.auto_en && (m_autoc == AF - 1);
            m_anim = (m_anim + (1 << bus.speed)) % 1024;
            if (bus.auto_en) m_autoc++;
            if (np || expire) m_left = BF;
            else if (pp) m_paused = 1;
        end else if (np) begin
            m_left = BF;
        end else if (pp) begin
            m_paused = 0;
        end
    endtask

    task automatic tick(input int n = 1);
        bit seen;
        repeat (n) begin
            seen = 0;
            for (int i = 0; i < 64 && !seen; i++) begin
                @(posedge clk);
                seen = (pos == 4'd0);
            end
            assert (seen) else begin
                miscompares++;
                $error("FAIL tick_timeout: observed no frame_tick, expected one within 64 clk");
            end
            if (seen) model_step();
            #1;
            chk_model();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk_model();
    endtask

    initial begin
        bus.btn_next = 1'b1;
        bus.btn_pause = 1'b1;
        bus.auto_en = 1'b0;
        bus.speed = 2'd0;
        model_reset();
        // reset with both buttons held
        do_reset(3);
        chk("rst_sel", 32'(bus.pattern_sel), 32'd0);
        chk("rst_anim", 32'(bus.anim_count), 32'd0);
        chk("rst_blank", 32'(bus.blank), 32'd0);
        chk("rst_paused", 32'(bus.paused), 32'd0);
        tick();
        chk("no_early_press", 32'(bus.blank), 32'd0);
        tick();
        bus.btn_next = 1'b0;
        bus.btn_pause = 1'b0;
        tick(4);
        // animation step and wrap
        do_reset(1);
        bus.speed = 2'd2;
        tick(5);
        chk("anim_speed2", 32'(bus.anim_count), 32'd20);
        bus.speed = 2'd3;
        tick(126);
        chk("anim_wrap", 32'(bus.anim_count), 32'd4);
        // auto advance
        do_reset(1);
        bus.speed = 2'd0;
        bus.auto_en = 1'b1;
        tick(8);
        chk("auto_blank", 32'(bus.blank), 32'd1);
        tick(2);
        chk("auto_sel", 32'(bus.pattern_sel), 32'd1);
        chk("auto_anim0", 32'(bus.anim_count), 32'd0);
        chk("auto_unblank", 32'(bus.blank), 32'd0);
        tick(30);
        chk("auto_sel_wrap", 32'(bus.pattern_sel), 32'd0);
        // debounce
        do_reset(1);
        bus.auto_en = 1'b0;
        bus.btn_next = 1'b1;
        tick();
        bus.btn_next = 1'b0;
        tick(3);
        chk("glitch_blank", 32'(bus.blank), 32'd0);
        chk("glitch_sel", 32'(bus.pattern_sel), 32'd0);
        bus.btn_next = 1'b1;
        tick(2);
        chk("deb_blank", 32'(bus.blank), 32'd1);
        bus.btn_next = 1'b0;
        tick(2);
        chk("deb_sel", 32'(bus.pattern_sel), 32'd1);
        // pause, switch while paused, pause press during blank
        bus.btn_pause = 1'b1;
        tick(2);
        chk("pause_on", 32'(bus.paused), 32'd1);
        bus.btn_pause = 1'b0;
        tick(6);
        chk("anim_frozen", 32'(bus.anim_count), 32'd2);
        bus.btn_next = 1'b1;
        tick(2);
        chk("paused_blank", 32'(bus.blank), 32'd1);
        bus.btn_next = 1'b0;
        bus.btn_pause = 1'b1;
        tick(2);
        chk("paused_sel", 32'(bus.pattern_sel), 32'd2);
        chk("blank_pause_ignored", 32'(bus.paused), 32'd1);
        chk("paused_unblank", 32'(bus.blank), 32'd0);
        bus.btn_pause = 1'b0;
        tick(2);
        bus.btn_pause = 1'b1;
        tick(2);
        chk("pause_off", 32'(bus.paused), 32'd0);
        bus.btn_pause = 1'b0;
        tick(3);
        chk("anim_resume", 32'(bus.anim_count), 32'd3);
        // auto expiry and manual press on the same tick, then reset mid-blank
        do_reset(1);
        bus.auto_en = 1'b1;
        bus.speed = 2'd1;
        tick(6);
        bus.btn_next = 1'b1;
        tick(2);
        chk("simul_blank", 32'(bus.blank), 32'd1);
        bus.btn_next = 1'b0;
        tick(2);
        chk("simul_single_adv", 32'(bus.pattern_sel), 32'd1);
        tick(8);
        chk("second_blank", 32'(bus.blank), 32'd1);
        tick();
        do_reset(1);
        chk("midblank_rst_sel", 32'(bus.pattern_sel), 32'd0);
        chk("midblank_rst_blank", 32'(bus.blank), 32'd0);
        tick(4);
        // no frame_tick: everything holds even with inputs moving
        hold_pos = 1'b1;
        bus.btn_next = 1'b1;
        bus.btn_pause = 1'b1;
        bus.speed = 2'd3;
        repeat (40) @(posedge clk);
        #1;
        chk_model();
        bus.btn_next = 1'b0;
        bus.btn_pause = 1'b0;
        hold_pos = 1'b0;
        tick(3);
        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.btn_next = ~bus.btn_next;
            if ($urandom_range(0, 4) == 0) bus.btn_pause = ~bus.btn_pause;
            if ($urandom_range(0, 19) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 9) == 0) bus.speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) do_reset(1);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
